// File: rtl/tss_cmd_serializer.sv
// tss_cmd_serializer: classifies host commands by header and streams them as AXI-Stream frames
package tss_pkg;
  localparam logic [7:0] START_HEADER    = 8'hA1;
  localparam logic [7:0] STOP_HEADER     = 8'hA2;
  localparam logic [7:0] CONTINUE_HEADER = 8'hA3;
  localparam logic [7:0] ABORT_HEADER    = 8'hA4;
endpackage

module tss_cmd_serializer #(
  parameter int CMD_WIDTH = 272,
  parameter int HDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [HDR_WIDTH-1:0] START_HDR = HDR_WIDTH'(tss_pkg::START_HEADER),
  parameter logic [HDR_WIDTH-1:0] STOP_HDR = HDR_WIDTH'(tss_pkg::STOP_HEADER),
  parameter logic [HDR_WIDTH-1:0] CONT_HDR = HDR_WIDTH'(tss_pkg::CONTINUE_HEADER),
  parameter logic [HDR_WIDTH-1:0] ABORT_HDR = HDR_WIDTH'(tss_pkg::ABORT_HEADER),
  parameter int LONG_BYTES = CMD_WIDTH/8,
  parameter int SHORT_BYTES = 9
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [CMD_WIDTH-1:0]    cmd_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  output logic [DATA_WIDTH-1:0]   tss_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] tss_axis_tkeep,
  output logic                    tss_axis_tvalid,
  input  logic                    tss_axis_tready,
  output logic                    tss_axis_tlast,
  output logic                    drop_o,
  output logic [15:0]             frame_cnt_o
);
  localparam int BPB = DATA_WIDTH/8;
  localparam int NBM = (CMD_WIDTH + DATA_WIDTH - 1)/DATA_WIDTH;
  localparam int NBYTES = NBM*BPB;
  localparam int CNT_W = $clog2(CMD_WIDTH/8 + 1);
  localparam int BIW = $clog2(NBYTES);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;
  logic [0:0]           r_state;
  logic [CMD_WIDTH-1:0] r_hold;
  logic [CNT_W-1:0]     r_beat;
  logic [CNT_W-1:0]     r_nb;
  logic [CNT_W-1:0]     r_len;
  logic                 r_drop;
  logic [15:0]          r_frames;
  logic [HDR_WIDTH-1:0] w_hdr;
  logic                 w_known;
  logic                 w_last;
  logic                 w_fin;
  logic                 w_acc;
  logic [CNT_W-1:0]     w_len;
  logic [CNT_W-1:0]     w_nb;
  logic [7:0]           w_bytes [NBYTES];
  assign w_hdr = cmd_i[HDR_WIDTH-1:0];
  assign w_known = (w_hdr != '0) &&
                   (w_hdr == START_HDR || w_hdr == STOP_HDR || w_hdr == CONT_HDR || w_hdr == ABORT_HDR);
  always_comb
    w_len = (w_hdr == START_HDR) ? CNT_W'(LONG_BYTES) :
            (w_hdr == STOP_HDR || w_hdr == CONT_HDR) ? CNT_W'(SHORT_BYTES) : CNT_W'(1);
  assign w_nb = CNT_W'((int'(w_len) + BPB - 1)/BPB);
  assign w_last = (r_state == S_SEND) && (r_beat == r_nb - 1'b1);
  assign w_fin = w_last && tss_axis_tready;
  assign cmd_ready_o = (r_state == S_IDLE) || w_fin;
  assign w_acc = cmd_valid_i && cmd_ready_o;
  // The final beat may run past the command word; those bytes read as zero.
  for (genvar i = 0; i < NBYTES; i++) begin : g_byte
    if (i < CMD_WIDTH/8) begin : g_in
      assign w_bytes[i] = r_hold[i*8 +: 8];
    end else begin : g_pad
      assign w_bytes[i] = 8'h00;
    end
  end
  always_comb begin
    tss_axis_tdata = '0;
    tss_axis_tkeep = '0;
    for (int b = 0; b < BPB; b++) begin
      tss_axis_tkeep[b] = (r_state == S_SEND) && (int'(r_beat)*BPB + b < int'(r_len));
      tss_axis_tdata[b*8 +: 8] = tss_axis_tkeep[b] ? w_bytes[BIW'(int'(r_beat)*BPB + b)] : 8'h00;
    end
  end
  assign tss_axis_tvalid = (r_state == S_SEND);
  assign tss_axis_tlast = w_last;
  assign drop_o = r_drop;
  assign frame_cnt_o = r_frames;
  always_ff @(posedge clk) begin
    if (arst) begin
      r_state <= S_IDLE;
      r_hold <= '0;
      r_beat <= '0;
      r_nb <= '0;
      r_len <= '0;
      r_drop <= 1'b0;
      r_frames <= '0;
    end else begin
      r_drop <= w_acc && !w_known;
      if (w_fin) r_frames <= r_frames + 16'd1;
      if (w_acc && w_known) begin
        r_state <= S_SEND;
        r_hold <= cmd_i;
        r_len <= w_len;
        r_nb <= w_nb;
        r_beat <= '0;
      end else if (w_fin) r_state <= S_IDLE;
      else if (r_state == S_SEND && tss_axis_tready) r_beat <= r_beat + 1'b1;
    end
  end
endmodule
